// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg
// Shared definitions for the byte-wide ROM fetch/load arbiter:
//   state_t             - controller FSM states
//   size_t              - load size encoding (SZ_BYTE / SZ_WORD)
//   WAIT_CYCLES_DEFAULT - default ROM access wait, in clk cycles
//   last_index()        - index of the final byte lane for a given size
package rom_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } size_t;

  localparam int WAIT_CYCLES_DEFAULT = 1;

  // Byte count is stored as the last lane index so it fits the 2-bit index.
  function automatic logic [1:0] last_index(input logic size);
    return (size_t'(size) == SZ_WORD) ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/rom_fetch_arb_if.sv
// rom_fetch_arb_if
// Bundles the two requester ports and the ROM port of rom_fetch_arb.
//   if_req/if_addr/if_ack/if_rdata           - instruction fetch (word)
//   ld_req/ld_addr/ld_size/ld_ack/ld_rdata   - data load (byte or word)
//   rom_addr/rom_trigger/rom_data            - byte-wide ROM
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus ROM)
interface rom_fetch_arb_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_size;
  logic        ld_ack;
  logic [31:0] ld_rdata;

  logic [31:0] rom_addr;
  logic        rom_trigger;
  logic [7:0]  rom_data;

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, ld_size, rom_data,
    output if_ack, if_rdata, ld_ack, ld_rdata, rom_addr, rom_trigger
  );

  modport master (
    output if_req, if_addr, ld_req, ld_addr, ld_size, rom_data,
    input  if_ack, if_rdata, ld_ack, ld_rdata, rom_addr, rom_trigger
  );

endinterface

// File: rtl/rom_fetch_arb_rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter. When both inputs request, the one that
// was not granted last wins. The last-grant register resets to "b" so
// input "a" wins the first contested round.
//   clk, rst_n        - clock, async active-low reset
//   req_a, req_b      - requests
//   update            - commit the current grant as the last grant
//   grant_a, grant_b  - combinational one-hot (or zero) grant
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic grant_a,
  output logic grant_b
);

  logic last_b;

  always_comb begin
    grant_a = req_a & (~req_b | last_b);
    grant_b = req_b & (~req_a | ~last_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (update && (req_a || req_b)) begin
      last_b <= grant_b;
    end
  end

endmodule

// File: rtl/rom_fetch_arb.sv
// rom_fetch_arb
// Shares one byte-wide ROM between an instruction-fetch port (word reads)
// and a data-load port (byte or word reads). Each byte costs an ISSUE
// cycle (address + trigger toggle), WAIT_CYCLES wait cycles and a CAPTURE
// cycle; bytes assemble little-endian and the granted port gets a
// one-cycle ack in DONE.
//   clk, rst_n - clock, async active-low reset
//   bus        - rom_fetch_arb_if.slave (requester and ROM signals)
// Parameter WAIT_CYCLES: cycles between trigger toggle and data sample, 1..15.
module rom_fetch_arb
  import rom_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  rom_fetch_arb_if.slave  bus
);

  state_t      state;
  logic        sel_ld;
  logic [31:0] base;
  logic [1:0]  last_idx;
  logic [1:0]  idx;
  logic [3:0]  wait_cnt;
  logic [31:0] asm_data;
  logic [31:0] asm_next;
  logic        grant_if;
  logic        grant_ld;
  logic        arb_update;

  assign arb_update = (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (bus.if_req),
    .req_b   (bus.ld_req),
    .update  (arb_update),
    .grant_a (grant_if),
    .grant_b (grant_ld)
  );

  // Assembly register with the current ROM byte dropped into lane idx,
  // so the final capture can publish the complete word in the same edge.
  always_comb begin
    asm_next = asm_data;
    asm_next[{idx, 3'b000} +: 8] = bus.rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      sel_ld          <= 1'b0;
      base            <= '0;
      last_idx        <= '0;
      idx             <= '0;
      wait_cnt        <= '0;
      asm_data        <= '0;
      bus.rom_addr    <= '0;
      bus.rom_trigger <= 1'b0;
      bus.if_ack      <= 1'b0;
      bus.ld_ack      <= 1'b0;
      bus.if_rdata    <= '0;
      bus.ld_rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.if_req || bus.ld_req) begin
            sel_ld   <= grant_ld;
            base     <= grant_if ? bus.if_addr : bus.ld_addr;
            last_idx <= grant_ld ? last_index(bus.ld_size) : last_index(SZ_WORD);
            idx      <= '0;
            asm_data <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Address arithmetic wraps naturally at 2^32.
          bus.rom_addr    <= base + {30'd0, idx};
          bus.rom_trigger <= ~bus.rom_trigger;
          wait_cnt        <= 4'(WAIT_CYCLES - 1);
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          asm_data <= asm_next;
          if (idx == last_idx) begin
            state <= ST_DONE;
            if (sel_ld) begin
              bus.ld_rdata <= asm_next;
              bus.ld_ack   <= 1'b1;
            end else begin
              bus.if_rdata <= asm_next;
              bus.if_ack   <= 1'b1;
            end
          end else begin
            idx   <= idx + 2'd1;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          bus.if_ack <= 1'b0;
          bus.ld_ack <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_arb.sv
// tb_rom_fetch_arb
// Self-checking bench for rom_fetch_arb: a table of hand-computed vectors,
// hand sequences for alternation, wrap-around, mid-transaction reset and a
// WAIT_CYCLES=3 instance, then randomized rounds checked against a model
// built from the latency formula, round-robin rule and ROM contents.
`timescale 1ns/1ps
module tb_rom_fetch_arb;
  import rom_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_fetch_arb_if bus ();
  rom_fetch_arb_if bus3 ();

  rom_fetch_arb #(.WAIT_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rom_fetch_arb #(.WAIT_CYCLES(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] addrSeq[$];

  // Model state
  bit          modelLastLd;
  logic [31:0] modelIfData;
  logic [31:0] modelLdData;

  // ROM contents: fixed bytes where the checks need them, a hash elsewhere.
  function automatic logic [7:0] romByte(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 8'h11;
      32'h0000_0011: return 8'h22;
      32'h0000_0012: return 8'h33;
      32'h0000_0013: return 8'h44;
      32'h0000_0020: return 8'hAB;
      32'hFFFF_FFFE: return 8'hA1;
      32'hFFFF_FFFF: return 8'hA2;
      32'h0000_0000: return 8'hB1;
      32'h0000_0001: return 8'hB2;
      default:       return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  always_comb bus.rom_data = romByte(bus.rom_addr);
  always_comb bus3.rom_data = romByte(bus3.rom_addr);

  function automatic int byteCount(input logic sizeWord);
    return sizeWord ? 4 : 1;
  endfunction

  function automatic int latency(input logic sizeWord, input int w);
    return 1 + byteCount(sizeWord) * (2 + w);
  endfunction

  function automatic logic [31:0] expData(input logic [31:0] addr, input logic sizeWord);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < byteCount(sizeWord); i++) begin
      d = d | (32'(romByte(addr + 32'(i))) << (8 * i));
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rom_addr"}, bus.rom_addr, 32'h0);
    checkOutput({tag, " rom_trigger"}, 32'(bus.rom_trigger), 32'h0);
    checkOutput({tag, " if_ack"}, 32'(bus.if_ack), 32'h0);
    checkOutput({tag, " ld_ack"}, 32'(bus.ld_ack), 32'h0);
    checkOutput({tag, " if_rdata"}, bus.if_rdata, 32'h0);
    checkOutput({tag, " ld_rdata"}, bus.ld_rdata, 32'h0);
  endtask

  // Pulses reset and leaves the bench 1 time unit after a rising edge.
  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelLastLd = 1'b1;
    modelIfData = '0;
    modelLdData = '0;
  endtask

  // One round: present the requests, hold each until its ack, record ack
  // cycles, data and ROM trigger activity, then compare.
  task automatic applyStimulus(input string tag,
                               input bit ifOn, input logic [31:0] ifAddr,
                               input bit ldOn, input logic [31:0] ldAddr, input logic ldSize,
                               input int expIfCycle, input logic [31:0] expIfData,
                               input int expLdCycle, input logic [31:0] expLdData,
                               input int expToggles);
    int gotIf = 0;
    int gotLd = 0;
    int toggles = 0;
    int extra = 0;
    int budget;
    logic [31:0] ifData;
    logic [31:0] ldData;
    logic prevTrig;
    budget = ((expIfCycle > expLdCycle) ? expIfCycle : expLdCycle) + 8;
    addrSeq.delete();
    ifData = '0;
    ldData = '0;
    prevTrig = bus.rom_trigger;
    bus.if_addr = ifAddr;
    bus.ld_addr = ldAddr;
    bus.ld_size = ldSize;
    bus.if_req = ifOn;
    bus.ld_req = ldOn;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (bus.rom_trigger !== prevTrig) begin
        toggles++;
        addrSeq.push_back(bus.rom_addr);
        prevTrig = bus.rom_trigger;
      end
      if (bus.if_ack === 1'b1) begin
        if (bus.if_req && gotIf == 0) begin
          gotIf = n;
          ifData = bus.if_rdata;
          bus.if_req = 1'b0;
        end else begin
          extra++;
        end
      end
      if (bus.ld_ack === 1'b1) begin
        if (bus.ld_req && gotLd == 0) begin
          gotLd = n;
          ldData = bus.ld_rdata;
          bus.ld_req = 1'b0;
        end else begin
          extra++;
        end
      end
      if ((!ifOn || gotIf != 0) && (!ldOn || gotLd != 0)) break;
    end
    bus.if_req = 1'b0;
    bus.ld_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.if_ack !== 1'b0 || bus.ld_ack !== 1'b0) extra++;
    end
    if (ifOn) begin
      checkOutput({tag, " if_ack cycle"}, 32'(gotIf), 32'(expIfCycle));
      checkOutput({tag, " if_rdata"}, ifData, expIfData);
    end else begin
      checkOutput({tag, " if_rdata held"}, bus.if_rdata, expIfData);
    end
    if (ldOn) begin
      checkOutput({tag, " ld_ack cycle"}, 32'(gotLd), 32'(expLdCycle));
      checkOutput({tag, " ld_rdata"}, ldData, expLdData);
    end else begin
      checkOutput({tag, " ld_rdata held"}, bus.ld_rdata, expLdData);
    end
    checkOutput({tag, " trigger toggles"}, 32'(toggles), 32'(expToggles));
    checkOutput({tag, " stray acks"}, 32'(extra), 32'h0);
  endtask

  typedef struct {
    bit          ifOn;
    logic [31:0] ifAddr;
    bit          ldOn;
    logic [31:0] ldAddr;
    logic        ldSize;
    int          expIfCycle;
    logic [31:0] expIfData;
    int          expLdCycle;
    logic [31:0] expLdData;
    int          expToggles;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] wrapSeq[4];
    int expPort[4];
    int expCyc[4];
    logic [31:0] expDat[4];
    int gotAcks;

    wrapSeq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    expPort = '{0, 1, 0, 1};
    expCyc = '{13, 18, 32, 37};
    expDat = '{32'h4433_2211, 32'h0000_00AB, 32'h4433_2211, 32'h0000_00AB};

    // Table: expected values worked out by hand from the ROM contents.
    // Rows run back to back, so the round-robin history carries over.
    vecs[0] = '{1, 32'h10,        0, 32'h0,  SZ_BYTE, 13, 32'h4433_2211, 0,  32'h0,         4};
    vecs[1] = '{0, 32'h0,         1, 32'h20, SZ_BYTE, 0,  32'h4433_2211, 4,  32'h0000_00AB, 1};
    vecs[2] = '{1, 32'hFFFF_FFFE, 0, 32'h0,  SZ_BYTE, 13, 32'hB2B1_A2A1, 0,  32'h0000_00AB, 4};
    vecs[3] = '{1, 32'h10,        1, 32'h20, SZ_BYTE, 18, 32'h4433_2211, 4,  32'h0000_00AB, 5};
    vecs[4] = '{0, 32'h0,         1, 32'h13, SZ_BYTE, 0,  32'h4433_2211, 4,  32'h0000_0044, 1};
    vecs[5] = '{1, 32'hFFFF_FFFE, 1, 32'h01, SZ_BYTE, 13, 32'hB2B1_A2A1, 18, 32'h0000_00B2, 5};
    vecs[6] = '{0, 32'h0,         1, 32'h11, SZ_WORD, 0,  32'hB2B1_A2A1, 13, 32'h4E44_3322, 4};

    rst_n = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.ld_req = 1'b0;
    bus.ld_addr = '0;
    bus.ld_size = 1'b0;
    bus3.if_req = 1'b0;
    bus3.if_addr = '0;
    bus3.ld_req = 1'b0;
    bus3.ld_addr = '0;
    bus3.ld_size = 1'b0;
    #12;
    checkResetValues("power-on");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i),
                    vecs[i].ifOn, vecs[i].ifAddr, vecs[i].ldOn, vecs[i].ldAddr, vecs[i].ldSize,
                    vecs[i].expIfCycle, vecs[i].expIfData, vecs[i].expLdCycle, vecs[i].expLdData,
                    vecs[i].expToggles);
      if (i == 2) begin
        checkOutput("wrap addr count", 32'(addrSeq.size()), 32'd4);
        for (int k = 0; k < 4 && k < addrSeq.size(); k++) begin
          checkOutput($sformatf("wrap rom_addr[%0d]", k), addrSeq[k], wrapSeq[k]);
        end
      end
    end

    // Both requests held continuously from reset: if, ld, if, ld.
    doReset();
    bus.if_addr = 32'h10;
    bus.ld_addr = 32'h20;
    bus.ld_size = SZ_BYTE;
    bus.if_req = 1'b1;
    bus.ld_req = 1'b1;
    gotAcks = 0;
    for (int n = 1; n <= 60 && gotAcks < 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.if_ack === 1'b1 || bus.ld_ack === 1'b1) begin
        checkOutput($sformatf("alt port[%0d]", gotAcks), 32'(bus.ld_ack), 32'(expPort[gotAcks]));
        checkOutput($sformatf("alt cycle[%0d]", gotAcks), 32'(n), 32'(expCyc[gotAcks]));
        checkOutput($sformatf("alt data[%0d]", gotAcks),
                    bus.ld_ack ? bus.ld_rdata : bus.if_rdata, expDat[gotAcks]);
        gotAcks++;
        if (gotAcks == 4) begin
          bus.if_req = 1'b0;
          bus.ld_req = 1'b0;
        end
      end
    end
    bus.if_req = 1'b0;
    bus.ld_req = 1'b0;
    checkOutput("alt ack count", 32'(gotAcks), 32'd4);
    repeat (2) @(posedge clk);
    #1;

    // Reset during WAIT of the second byte; the request is held throughout.
    bus.if_addr = 32'h10;
    bus.if_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midreset rom_addr before", bus.rom_addr, 32'h11);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("midreset ack held low", 32'(bus.if_ack | bus.ld_ack), 32'h0);
    end
    rst_n = 1'b1;
    gotAcks = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (bus.if_ack === 1'b1) begin
        gotAcks = n;
        checkOutput("midreset retry data", bus.if_rdata, 32'h4433_2211);
        bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0;
    checkOutput("midreset retry cycle", 32'(gotAcks), 32'd13);
    repeat (2) @(posedge clk);
    #1;

    // WAIT_CYCLES = 3 instance, word load.
    begin
      int toggles3 = 0;
      logic prev3;
      prev3 = bus3.rom_trigger;
      bus3.ld_addr = 32'h10;
      bus3.ld_size = SZ_WORD;
      bus3.ld_req = 1'b1;
      gotAcks = 0;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk);
        #1;
        if (bus3.rom_trigger !== prev3) begin
          toggles3++;
          prev3 = bus3.rom_trigger;
        end
        if (bus3.ld_ack === 1'b1) begin
          gotAcks = n;
          checkOutput("wait3 ld_rdata", bus3.ld_rdata, 32'h4433_2211);
          bus3.ld_req = 1'b0;
          break;
        end
      end
      bus3.ld_req = 1'b0;
      checkOutput("wait3 ld_ack cycle", 32'(gotAcks), 32'd21);
      checkOutput("wait3 toggles", 32'(toggles3), 32'd4);
    end

    // Randomized rounds against the model.
    doReset();
    for (int r = 0; r < 40; r++) begin
      int pat;
      bit ifOn;
      bit ldOn;
      logic ldSize;
      logic [31:0] ifAddr;
      logic [31:0] ldAddr;
      int ifCyc;
      int ldCyc;
      int toggles;
      pat = int'($urandom_range(1, 3));
      ifOn = pat[0];
      ldOn = pat[1];
      ldSize = 1'($urandom_range(0, 1));
      ifAddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
      ldAddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
      ifCyc = 0;
      ldCyc = 0;
      toggles = 0;
      if (ifOn) toggles += 4;
      if (ldOn) toggles += byteCount(ldSize);
      if (ifOn && ldOn) begin
        if (modelLastLd) begin
          ifCyc = latency(1'b1, 1);
          ldCyc = ifCyc + 1 + latency(ldSize, 1);
          modelLastLd = 1'b1;
        end else begin
          ldCyc = latency(ldSize, 1);
          ifCyc = ldCyc + 1 + latency(1'b1, 1);
          modelLastLd = 1'b0;
        end
      end else if (ifOn) begin
        ifCyc = latency(1'b1, 1);
        modelLastLd = 1'b0;
      end else begin
        ldCyc = latency(ldSize, 1);
        modelLastLd = 1'b1;
      end
      if (ifOn) modelIfData = expData(ifAddr, 1'b1);
      if (ldOn) modelLdData = expData(ldAddr, ldSize);
      applyStimulus($sformatf("rnd%0d", r), ifOn, ifAddr, ldOn, ldAddr, ldSize,
                    ifCyc, modelIfData, ldCyc, modelLdData, toggles);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arb.md
ROM_FETCH_ARB -- requirements
Module: rom_fetch_arb

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: clk cycles between rom_trigger toggle and rom_data sample, legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 if_req  input  1  instruction-fetch request, word read.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ack  output  1  one-cycle pulse, if_rdata valid.
REQ-007 if_rdata  output  32  fetched word.
REQ-008 ld_req  input  1  data-load request.
REQ-009 ld_addr  input  32  load byte address.
REQ-010 ld_size  input  1  0 = byte, 1 = word.
REQ-011 ld_ack  output  1  one-cycle pulse, ld_rdata valid.
REQ-012 ld_rdata  output  32  loaded data.
REQ-013 rom_addr  output  32  byte address to the byte-wide ROM.
REQ-014 rom_trigger  output  1  toggled once per byte read; ROM reads on either edge.
REQ-015 rom_data  input  8  ROM byte for the current rom_addr.

Function
REQ-016 Requester holds req, addr and size stable from assertion until its ack; block samples them only in IDLE.
REQ-017 FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-018 IDLE: on any req, latch the grant, base address and byte count (word = 4, byte = 1); clear byte index; go to ISSUE next cycle.
REQ-019 Arbitration is 2-way round-robin: both requesting -> grant the requester not granted last; after reset, ifetch has priority.
REQ-020 ISSUE: rom_addr = base + index (modulo 2^32); toggle rom_trigger; go to WAIT.
REQ-021 WAIT: hold for WAIT_CYCLES cycles, then go to CAPTURE.
REQ-022 CAPTURE: store rom_data into byte lane index (little-endian: base byte -> bits 7:0); if index = count-1 -> DONE, else index+1 -> ISSUE.
REQ-023 DONE: granted ack high for exactly one cycle with rdata valid; return to IDLE.
REQ-024 Latency from req sampled in IDLE to ack high = 1 + count*(2+WAIT_CYCLES) cycles (word 13, byte 4 at WAIT_CYCLES=1).
REQ-025 Byte load: ld_rdata = {24'h0, byte}; no alignment check; words cross any boundary.
REQ-026 Address wrap: base 0xFFFFFFFE word reads bytes FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-027 rdata holds its value after ack until the next completion for that port; the non-granted port's ack stays 0.
REQ-028 A req still high in the cycle after its ack is a new request (arbitrated in IDLE).
REQ-029 rom_addr and rom_trigger change only in ISSUE; no other outputs change outside DONE/CAPTURE.

Reset
REQ-030 While rst_n = 0: state IDLE, rom_addr = 0, rom_trigger = 0, if_ack = ld_ack = 0, if_rdata = ld_rdata = 0, last-grant = ld (so ifetch wins first).
REQ-031 Reset mid-transaction abandons it with no ack; the requester re-presents after reset; a spurious ROM read caused by trigger returning to 0 is harmless.

Structure
REQ-032 Shared package/header rom_ctrl_pkg holds state encoding, size encoding (SZ_BYTE, SZ_WORD) and WAIT_CYCLES default.
REQ-033 Sub-module rr_arb2: 2-input round-robin arbiter with last-grant register, update enable from IDLE grant.
REQ-034 Wait counter 4 bits; byte index 2 bits; assembly register 32 bits.

Verification
REQ-035 ROM[0x10..0x13] = 11,22,33,44; if_req at 0x10 -> if_ack 13 cycles later, if_rdata = 0x44332211, four rom_trigger toggles.
REQ-036 ROM[0x20] = 0xAB; ld_req, ld_size = 0 at 0x20 -> ld_ack at cycle 4, ld_rdata = 0x000000AB, one toggle.
REQ-037 if_req and ld_req raised same cycle after reset -> if served first, then ld; both held continuously -> grants alternate if, ld, if, ld.
REQ-038 if_req at 0xFFFFFFFE with ROM bytes A1,A2 at top, B1,B2 at 0,1 -> rom_addr sequence FFFFFFFE, FFFFFFFF, 0, 1; if_rdata = 0xB2B1A2A1.
REQ-039 rst_n low during WAIT of byte 2 -> all outputs at reset values, no ack; after release, same request completes with correct data.
REQ-040 WAIT_CYCLES = 3, word load -> ld_ack at cycle 21.
